// File: rtl/i2s_rx_pkg.sv
// Shared types for the I2S/TDM slave receiver: FSM state encoding and the
// lane-index width helper used for the output lane tag.
package i2s_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        OFFSET,
        RUN,
        DONE
    } state_e;

    // A single-lane build still needs a one-bit lane tag.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_rx_lane_deser.sv
// One serial lane: shift register (MSB- or LSB-first), right-alignment of
// LSB-first words and a holding register loaded when the word completes.
module i2s_rx_lane_deser
    import i2s_rx_pkg::*;
#(
    parameter int MAX_BITS = 32
) (
    input  logic                        i_sck,
    input  logic                        i_rstn,
    input  logic                        i_clear,
    input  logic                        i_capture,
    input  logic                        i_word_end,
    input  logic                        i_active,
    input  logic                        i_sd,
    input  logic                        i_lsb_first,
    input  logic [$clog2(MAX_BITS)-1:0] i_num_bits,
    output logic [MAX_BITS-1:0]         o_word
);

    localparam int BIT_W = $clog2(MAX_BITS);

    logic [MAX_BITS-1:0] r_shift;
    logic [MAX_BITS-1:0] r_hold;
    logic [MAX_BITS-1:0] w_shift_next;
    logic [MAX_BITS-1:0] w_aligned;
    logic [BIT_W-1:0]    w_rshift;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_shift_next = i_lsb_first ? {i_sd, r_shift[MAX_BITS-1:1]}
                                   : {r_shift[MAX_BITS-2:0], i_sd};
        w_rshift     = BIT_W'(MAX_BITS - 1) - i_num_bits;
        w_aligned    = i_lsb_first ? (w_shift_next >> w_rshift) : w_shift_next;
    end

    // The shift register restarts from zero each word, so MSB-first upper bits stay clean.
    // NOTE: the holding register is a handful of flops, not a RAM, so it takes the async reset too.
    always_ff @(posedge i_sck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shift <= '0;
            r_hold  <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_hold  <= '0;
        end else if (i_capture) begin
            r_shift <= i_word_end ? '0 : w_shift_next;
            if (i_word_end && i_active) begin
                r_hold <= w_aligned;
            end
        end
    end

    assign o_word = r_hold;

endmodule

// File: rtl/i2s_rx_tdm_channel.sv
// Multi-lane I2S/DSP slave receiver clocked by sck: frame sync, word
// deserialisation per lane, and a lane-0-first drain onto one valid/ready stream.
module i2s_rx_tdm_channel
    import i2s_rx_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_BITS  = 32,
    parameter int OFFSET_W  = 9,
    parameter int WCNT_W    = 16
) (
    input  logic                           sck_i,
    input  logic                           rstn_i,
    input  logic [NUM_LANES-1:0]           sd_i,
    input  logic                           ws_i,
    output logic [MAX_BITS-1:0]            fifo_data_o,
    output logic [lane_w(NUM_LANES)-1:0]   fifo_lane_o,
    output logic                           fifo_data_valid_o,
    input  logic                           fifo_data_ready_i,
    output logic                           fifo_err_o,
    output logic                           done_o,
    input  logic                           cfg_en_i,
    input  logic [$clog2(NUM_LANES):0]     cfg_num_lanes_i,
    input  logic [$clog2(MAX_BITS)-1:0]    cfg_num_bits_i,
    input  logic                           cfg_lsb_first_i,
    input  logic                           cfg_ws_fall_i,
    input  logic [OFFSET_W-1:0]            cfg_offset_i,
    input  logic                           cfg_continuous_i,
    input  logic [WCNT_W-1:0]              cfg_num_words_i
);

    localparam int LANE_W = lane_w(NUM_LANES);
    localparam int NL_W   = $clog2(NUM_LANES) + 1;
    localparam int BIT_W  = $clog2(MAX_BITS);

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_ws_q;
    logic [OFFSET_W-1:0]   r_off_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [WCNT_W-1:0]     r_word_cnt;
    logic [NUM_LANES-1:0]  r_pending;
    logic                  r_err;
    logic                  r_done;

    logic                  w_ws_edge;
    logic                  w_capture;
    logic                  w_word_end;
    logic                  w_last;
    logic                  w_overflow;
    logic                  w_valid;
    logic                  w_pop;
    logic [WCNT_W-1:0]     w_limit;
    logic [LANE_W-1:0]     w_sel;
    logic [NUM_LANES-1:0]  w_active;
    logic [NUM_LANES-1:0]  w_pending_next;
    logic [MAX_BITS-1:0]   w_hold [NUM_LANES];

    always_comb begin
        w_ws_edge = (r_ws_q != ws_i) && (ws_i == ~cfg_ws_fall_i);
        w_capture = 1'b0;
        case (r_state)
            SYNC:    w_capture = w_ws_edge && (cfg_offset_i == '0);
            OFFSET:  w_capture = (r_off_cnt == cfg_offset_i);
            RUN:     w_capture = 1'b1;
            default: w_capture = 1'b0;
        endcase
        w_capture  = w_capture && cfg_en_i;
        w_word_end = w_capture && (r_bit_cnt == cfg_num_bits_i);
        w_limit    = (cfg_num_words_i == '0) ? WCNT_W'(1) : cfg_num_words_i;
        w_last     = w_word_end && !cfg_continuous_i &&
                     (({1'b0, r_word_cnt} + (WCNT_W + 1)'(1)) == {1'b0, w_limit});
        w_overflow = w_word_end && (r_pending != '0);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   w_state_next = SYNC;
            SYNC: begin
                if (w_ws_edge) begin
                    if (cfg_offset_i != '0) w_state_next = OFFSET;
                    else                    w_state_next = w_last ? DONE : RUN;
                end
            end
            OFFSET: begin
                if (r_off_cnt == cfg_offset_i) w_state_next = w_last ? DONE : RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                if (r_pending == '0) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (!cfg_en_i) w_state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Priority drain: the lowest-index pending lane is presented first.
    always_comb begin
        w_sel = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (r_pending[l]) w_sel = LANE_W'(l);
        end
        w_valid = (r_pending != '0);
        w_pop   = w_valid && fifo_data_ready_i;
        w_pending_next = r_pending;
        if (w_pop)      w_pending_next[w_sel] = 1'b0;
        // A completion overwrites the holding registers, so it wins over a same-edge pop.
        if (w_word_end) w_pending_next = w_pending_next | w_active;
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ws_q     <= 1'b0;
            r_off_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_pending  <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ws_q <= ws_i;
            if (!cfg_en_i) begin
                r_off_cnt  <= '0;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_pending  <= '0;
                r_err      <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                r_pending <= w_pending_next;
                r_err     <= r_err | w_overflow;
                r_done    <= (r_state == DONE) && (r_pending == '0);
                if (r_state == SYNC && w_ws_edge) r_off_cnt <= OFFSET_W'(1);
                else if (r_state == OFFSET)       r_off_cnt <= r_off_cnt + OFFSET_W'(1);
                else                              r_off_cnt <= '0;
                if (w_capture) r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + BIT_W'(1);
                if (w_word_end && !cfg_continuous_i) r_word_cnt <= r_word_cnt + WCNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_active[g] = (cfg_num_lanes_i > NL_W'(g));

        i2s_rx_lane_deser #(
            .MAX_BITS (MAX_BITS)
        ) u_deser (
            .i_sck       (sck_i),
            .i_rstn      (rstn_i),
            .i_clear     (!cfg_en_i),
            .i_capture   (w_capture),
            .i_word_end  (w_word_end),
            .i_active    (w_active[g]),
            .i_sd        (sd_i[g]),
            .i_lsb_first (cfg_lsb_first_i),
            .i_num_bits  (cfg_num_bits_i),
            .o_word      (w_hold[g])
        );
    end

    assign fifo_data_valid_o = w_valid;
    assign fifo_data_o       = w_valid ? w_hold[w_sel] : '0;
    assign fifo_lane_o       = w_sel;
    assign fifo_err_o        = r_err;
    assign done_o            = r_done;

endmodule
